// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule definitions: permutation tables, rotation schedule, typedefs.
// Optional key parity helper is built only with DES_KEY_PARITY_CHECK_EN.
package des_pkg;

  localparam int unsigned KEY_W      = 64;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned SUBKEY_W   = 48;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned NUM_ROUNDS = 16;

  typedef logic [KEY_W:1]    key_t;
  typedef logic [HALF_W:1]   half_key_t;
  typedef logic [CD_W:1]     cd_t;
  typedef logic [SUBKEY_W:1] subkey_t;
  typedef logic [ROUND_W:1]  round_t;

  typedef enum logic {IDLE, RUN} state_t;

  // FIPS bit numbers (1 = MSB) selected for each output bit, MSB first.
  localparam byte unsigned PC1_TABLE [0:55] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam byte unsigned PC2_TABLE [0:47] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  localparam logic [1:0] SHIFT_SCHEDULE [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_key_t rotl(input half_key_t h, input logic [1:0] n);
    return (n == 2'd2) ? {h[26:1], h[28:27]} : {h[27:1], h[28]};
  endfunction

  function automatic half_key_t rotr(input half_key_t h, input logic [1:0] n);
    return (n == 2'd2) ? {h[2:1], h[28:3]} : {h[1], h[28:2]};
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  // DES requires odd parity per byte; flag any byte with even parity.
  function automatic logic key_parity_bad(input key_t k);
    return ~(^k[64:57]) | ~(^k[56:49]) | ~(^k[48:41]) | ~(^k[40:33]) |
           ~(^k[32:25]) | ~(^k[24:17]) | ~(^k[16:9])  | ~(^k[8:1]);
  endfunction
`endif

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load and subkey-stream handshake bundle for the DES key schedule.
interface des_key_schedule_if;
  import des_pkg::*;

  logic      key_valid;
  logic      key_ready;
  key_t      key;
  logic      decrypt;
  logic      subkey_valid;
  logic      subkey_ready;
  subkey_t   subkey;
  round_t    round;
  logic      key_parity_err;

  modport master (
    output key_valid, key, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round, key_parity_err
  );

  modport slave (
    input  key_valid, key, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round, key_parity_err
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// DES PC-2: pure wiring from the 56-bit C|D register pair to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  cd_t     cd,
  output subkey_t subkey
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[48-i] = cd[57 - int'(PC2_TABLE[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one key in, 16 round subkeys out in encrypt or decrypt order.
// Define DES_KEY_PARITY_CHECK_EN to build the per-byte odd-parity check on key load.
module des_key_schedule
  import des_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  des_key_schedule_if.slave  bus
);

  state_t    state;
  half_key_t c_q, d_q;
  round_t    round_q;
  logic      decrypt_q;
  logic      key_ready_q;
  logic      subkey_valid_q;
  cd_t       pc1_cd;
  half_key_t c_load, d_load;
  round_t    round_inc, round_dec;
  logic      last_round;
  subkey_t   subkey_w;

  // PC-1: FIPS bit j of the key sits at key[65-j].
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_cd[56-i] = bus.key[65 - int'(PC1_TABLE[i])];
  end

  assign c_load     = pc1_cd[56:29];
  assign d_load     = pc1_cd[28:1];
  assign round_inc  = round_t'(round_q + round_t'(1));
  assign round_dec  = round_t'(round_q - round_t'(1));
  assign last_round = decrypt_q ? (round_q == round_t'(0)) : (round_q == round_t'(15));

  // Control and C/D state; decrypt loads C0/D0 directly since it equals C16/D16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      c_q            <= '0;
      d_q            <= '0;
      round_q        <= '0;
      decrypt_q      <= 1'b0;
      key_ready_q    <= 1'b1;
      subkey_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            state          <= RUN;
            key_ready_q    <= 1'b0;
            subkey_valid_q <= 1'b1;
            decrypt_q      <= bus.decrypt;
            if (bus.decrypt) begin
              c_q     <= c_load;
              d_q     <= d_load;
              round_q <= round_t'(15);
            end else begin
              c_q     <= rotl(c_load, 2'd1);
              d_q     <= rotl(d_load, 2'd1);
              round_q <= round_t'(0);
            end
          end
        end
        RUN: begin
          if (bus.subkey_ready) begin
            if (last_round) begin
              state          <= IDLE;
              key_ready_q    <= 1'b1;
              subkey_valid_q <= 1'b0;
            end else if (decrypt_q) begin
              c_q     <= rotr(c_q, SHIFT_SCHEDULE[round_q]);
              d_q     <= rotr(d_q, SHIFT_SCHEDULE[round_q]);
              round_q <= round_dec;
            end else begin
              c_q     <= rotl(c_q, SHIFT_SCHEDULE[round_inc]);
              d_q     <= rotl(d_q, SHIFT_SCHEDULE[round_inc]);
              round_q <= round_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey_w)
  );

  assign bus.key_ready    = key_ready_q;
  assign bus.subkey_valid = subkey_valid_q;
  assign bus.subkey       = subkey_w;
  assign bus.round        = round_q;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_err_q;

  // Flag is captured only at load and held for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (state == IDLE && bus.key_valid) begin
      parity_err_q <= key_parity_bad(bus.key);
    end
  end

  assign bus.key_parity_err = parity_err_q;
`else
  logic unused_parity_bits;
  assign unused_parity_bits = ^{bus.key[57], bus.key[49], bus.key[41], bus.key[33],
                                bus.key[25], bus.key[17], bus.key[9],  bus.key[1]};
  assign bus.key_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed self-checking bench for des_key_schedule using the FIPS worked-example key.
module tb_des_key_schedule;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  localparam logic [64:1] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [48:1] EXP_K [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a key for exactly one accepting edge; called at posedge+1.
  task automatic load_key(input logic [64:1] k, input logic dec);
    bus.key       = k;
    bus.decrypt   = dec;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b want 1", bus.key_ready); end
    checks++; if (bus.subkey_valid !== 1'b0) begin errors++; $display("FAIL reset_subkey_valid: got %b want 0", bus.subkey_valid); end
    checks++; if (bus.round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", bus.round); end
    checks++; if (bus.subkey !== 48'h0) begin errors++; $display("FAIL reset_subkey: got %h want 0", bus.subkey); end
    checks++; if (bus.key_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", bus.key_parity_err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt;
    bus.subkey_ready = 1'b1;
    load_key(KEY_A, 1'b0);
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL enc_busy_ready: got %b want 0", bus.key_ready); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.subkey_valid !== 1'b1 || bus.subkey !== EXP_K[k] || bus.round !== 4'(k)) begin
        errors++;
        $display("FAIL enc_k%0d: valid=%b subkey=%h round=%0d want valid=1 subkey=%h round=%0d",
                 k + 1, bus.subkey_valid, bus.subkey, bus.round, EXP_K[k], k);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.subkey_valid !== 1'b0) begin
      errors++; $display("FAIL enc_done: key_ready=%b subkey_valid=%b want 1/0", bus.key_ready, bus.subkey_valid);
    end
  endtask

  task automatic test_decrypt;
    bus.subkey_ready = 1'b1;
    load_key(KEY_A, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.subkey_valid !== 1'b1 || bus.subkey !== EXP_K[15-k] || bus.round !== 4'(15 - k)) begin
        errors++;
        $display("FAIL dec_step%0d: valid=%b subkey=%h round=%0d want valid=1 subkey=%h round=%0d",
                 k, bus.subkey_valid, bus.subkey, bus.round, EXP_K[15-k], 15 - k);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.subkey_valid !== 1'b0) begin
      errors++; $display("FAIL dec_done: key_ready=%b subkey_valid=%b want 1/0", bus.key_ready, bus.subkey_valid);
    end
  endtask

  task automatic test_backpressure;
    int            idx;
    int            stalls;
    logic          rdy;
    logic [48:1]   prev_sk;
    logic [4:1]    prev_rd;
    idx    = 0;
    stalls = 0;
    bus.subkey_ready = 1'b0;
    load_key(KEY_A, 1'b0);
    for (int cyc = 0; cyc < 300 && idx < 16; cyc++) begin
      checks++;
      if (bus.subkey_valid !== 1'b1 || bus.subkey !== EXP_K[idx] || bus.round !== 4'(idx)) begin
        errors++;
        $display("FAIL bp_k%0d: valid=%b subkey=%h round=%0d want valid=1 subkey=%h round=%0d",
                 idx + 1, bus.subkey_valid, bus.subkey, bus.round, EXP_K[idx], idx);
      end
      prev_sk = bus.subkey;
      prev_rd = bus.round;
      rdy = 1'($urandom_range(0, 1));
      bus.subkey_ready = rdy;
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
      end else begin
        stalls++;
        checks++;
        if (bus.subkey !== prev_sk || bus.round !== prev_rd || bus.subkey_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall: subkey=%h round=%0d valid=%b want subkey=%h round=%0d valid=1",
                   bus.subkey, bus.round, bus.subkey_valid, prev_sk, prev_rd);
        end
      end
    end
    bus.subkey_ready = 1'b1;
    checks++;
    if (idx != 16 || bus.key_ready !== 1'b1) begin
      errors++; $display("FAIL bp_count: handshakes=%0d key_ready=%b want 16/1", idx, bus.key_ready);
    end
  endtask

  task automatic test_busy_key;
    bus.subkey_ready = 1'b1;
    load_key(KEY_A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.key          = 64'hFFFFFFFFFFFFFFFF;
    bus.decrypt      = 1'b1;
    bus.key_valid    = 1'b1;
    bus.subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.key_ready !== 1'b0 || bus.subkey !== EXP_K[3] || bus.round !== 4'd3) begin
      errors++;
      $display("FAIL busy_hold: key_ready=%b subkey=%h round=%0d want 0 %h 3",
               bus.key_ready, bus.subkey, bus.round, EXP_K[3]);
    end
    bus.key_valid    = 1'b0;
    bus.subkey_ready = 1'b1;
    for (int k = 3; k < 16; k++) begin
      checks++;
      if (bus.subkey !== EXP_K[k] || bus.round !== 4'(k)) begin
        errors++;
        $display("FAIL busy_k%0d: subkey=%h round=%0d want subkey=%h round=%0d", k + 1, bus.subkey, bus.round, EXP_K[k], k);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    bus.subkey_ready = 1'b1;
    bus.key          = KEY_A;
    bus.decrypt      = 1'b0;
    bus.key_valid    = 1'b1;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (bus.round !== 4'd15 || bus.subkey !== EXP_K[15]) begin
      errors++; $display("FAIL b2b_last: round=%0d subkey=%h want 15 %h", bus.round, bus.subkey, EXP_K[15]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.key_ready !== 1'b1 || bus.subkey_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: key_ready=%b subkey_valid=%b want 1/0", bus.key_ready, bus.subkey_valid);
    end
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    checks++;
    if (bus.subkey_valid !== 1'b1 || bus.subkey !== EXP_K[0] || bus.round !== 4'd0) begin
      errors++; $display("FAIL b2b_reload: valid=%b subkey=%h round=%0d want 1 %h 0", bus.subkey_valid, bus.subkey, bus.round, EXP_K[0]);
    end
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun;
    bus.subkey_ready = 1'b1;
    load_key(KEY_A, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.key_ready !== 1'b1 || bus.subkey_valid !== 1'b0 || bus.round !== 4'd0 || bus.subkey !== 48'h0) begin
      errors++;
      $display("FAIL midrst: key_ready=%b valid=%b round=%0d subkey=%h want 1 0 0 0",
               bus.key_ready, bus.subkey_valid, bus.round, bus.subkey);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_key(KEY_A, 1'b0);
    checks++;
    if (bus.subkey !== EXP_K[0] || bus.round !== 4'd0 || bus.subkey_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_reload: subkey=%h round=%0d valid=%b want %h 0 1", bus.subkey, bus.round, bus.subkey_valid, EXP_K[0]);
    end
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic test_parity;
    logic exp_bad;
`ifdef DES_KEY_PARITY_CHECK_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    bus.subkey_ready = 1'b1;
    load_key(64'h0101010101010101, 1'b0);
    checks++;
    if (bus.key_parity_err !== 1'b0) begin errors++; $display("FAIL parity_odd: got %b want 0", bus.key_parity_err); end
    repeat (16) @(posedge clk);
    #1;
    load_key(64'h0001010101010101, 1'b0);
    checks++;
    if (bus.key_parity_err !== exp_bad || bus.subkey_valid !== 1'b1) begin
      errors++; $display("FAIL parity_even: err=%b valid=%b want %b 1", bus.key_parity_err, bus.subkey_valid, exp_bad);
    end
    for (int cyc = 0; cyc < 40 && bus.key_ready !== 1'b1; cyc++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.key_parity_err !== exp_bad) begin
      errors++; $display("FAIL parity_hold: key_ready=%b err=%b want 1 %b", bus.key_ready, bus.key_parity_err, exp_bad);
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst_n            = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key          = '0;
    bus.decrypt      = 1'b0;
    bus.subkey_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_busy_key();
    test_back_to_back();
    test_reset_midrun();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
